// File: rtl/afu_csr_pkg.sv
// rtl/afu_csr_pkg.sv - CSR indices, CCI-P MMIO slice types and write-merge helper for afu_csr
package afu_csr_pkg;

  typedef logic [14:0] t_csr_idx;

  localparam t_csr_idx CSR_DFH     = 15'd0;
  localparam t_csr_idx CSR_ID_L    = 15'd1;
  localparam t_csr_idx CSR_ID_H    = 15'd2;
  localparam t_csr_idx CSR_RSVD0   = 15'd3;
  localparam t_csr_idx CSR_RSVD1   = 15'd4;
  localparam t_csr_idx CSR_SCRATCH = 15'd5;
  localparam t_csr_idx CSR_CTRL    = 15'd6;
  localparam t_csr_idx CSR_STATUS  = 15'd7;
  localparam t_csr_idx CSR_ERROR   = 15'd8;
  localparam t_csr_idx CSR_CYCLE   = 15'd9;
  localparam int       CSR_NUM     = 10;

  localparam logic [63:0] AFU_DFH_DEFAULT = 64'h1000_0100_0000_0000;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
  } t_if_ccip_Rx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  // A 4 B write replaces only the addressed DWORD half; an 8 B write replaces all.
  function automatic logic [63:0] mergeWrite(input logic [63:0] old, input logic [63:0] wdata,
                                             input logic is8, input logic half);
    if (is8)       return wdata;
    else if (half) return {wdata[31:0], old[31:0]};
    else           return {old[63:32], wdata[31:0]};
  endfunction

endpackage

// File: rtl/afu_csr.sv
// rtl/afu_csr.sv - CCI-P MMIO CSR responder: DFH/ID, scratch, control, status, error and cycle registers
module afu_csr
  import afu_csr_pkg::*;
#(
  parameter logic [63:0] AFU_DFH  = AFU_DFH_DEFAULT,
  parameter logic [63:0] AFU_ID_L = 64'h0,
  parameter logic [63:0] AFU_ID_H = 64'h0
) (
  input  logic           pClk,
  input  logic           pck_cp2af_softReset_n,
  input  t_if_ccip_Rx    sRx,
  output t_if_ccip_c2_Tx c2Tx,
  output logic           ctrl_start,
  output logic [62:0]    ctrl_cfg,
  input  logic [63:0]    status,
  input  logic [63:0]    err_set,
  output logic [63:0]    err
);

  t_ccip_c0_ReqMmioHdr reqHdr;
  t_csr_idx            reqIdx;
  logic                reqHalf;
  logic                reqIs8;
  logic                reqLegal;
  logic                wrEn;
  logic [63:0]         wrData;
  logic [63:0]         ctrlMerged;
  logic [63:0]         errClr;
  logic                unusedRx;

  assign reqHdr   = sRx.c0.hdr;
  assign reqIdx   = reqHdr.address[15:1];
  assign reqHalf  = reqHdr.address[0];
  assign reqIs8   = (reqHdr.length == 2'd1);
  assign reqLegal = !(reqIs8 && reqHalf);
  assign wrEn     = sRx.c0.mmioWrValid && reqLegal;
  assign wrData   = sRx.c0.data[63:0];
  assign unusedRx = ^{sRx.c0TxAlmFull, sRx.c1TxAlmFull, sRx.c0.rspValid,
                      sRx.c0.data[511:64], reqHdr.rsvd};

  // CTRL bit0 is never stored, so it merges as 0 and only the incoming data can raise it.
  assign ctrlMerged = mergeWrite({ctrl_cfg, 1'b0}, wrData, reqIs8, reqHalf);
  assign errClr     = (wrEn && reqIdx == CSR_ERROR) ? mergeWrite(64'h0, wrData, reqIs8, reqHalf)
                                                    : 64'h0;

  logic [63:0] scratch;
  logic [63:0] cycleCnt;

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      scratch    <= 64'h0;
      ctrl_cfg   <= 63'h0;
      ctrl_start <= 1'b0;
      err        <= 64'h0;
      cycleCnt   <= 64'h0;
    end else begin
      if (wrEn && reqIdx == CSR_SCRATCH)
        scratch <= mergeWrite(scratch, wrData, reqIs8, reqHalf);
      if (wrEn && reqIdx == CSR_CTRL)
        ctrl_cfg <= ctrlMerged[63:1];
      ctrl_start <= wrEn && (reqIdx == CSR_CTRL) && ctrlMerged[0];
      err        <= (err & ~errClr) | err_set;
      if (wrEn && reqIdx == CSR_CYCLE)
        cycleCnt <= 64'h0;
      else
        cycleCnt <= cycleCnt + 64'd1;
    end
  end

  logic       rdValid1;
  logic [8:0] rdTid1;
  t_csr_idx   rdIdx1;
  logic       rdHalf1;
  logic       rdIs81;
  logic       rdZero1;

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      rdValid1 <= 1'b0;
      rdTid1   <= 9'h0;
      rdIdx1   <= '0;
      rdHalf1  <= 1'b0;
      rdIs81   <= 1'b0;
      rdZero1  <= 1'b0;
    end else begin
      rdValid1 <= sRx.c0.mmioRdValid;
      rdTid1   <= reqHdr.tid;
      rdIdx1   <= reqIdx;
      rdHalf1  <= reqHalf;
      rdIs81   <= reqIs8;
      rdZero1  <= !reqLegal || (reqIdx >= t_csr_idx'(CSR_NUM));
    end
  end

  logic [63:0] regVal;
  logic [63:0] rdData;

  always_comb begin
    regVal = 64'h0;
    case (rdIdx1)
      CSR_DFH:     regVal = AFU_DFH;
      CSR_ID_L:    regVal = AFU_ID_L;
      CSR_ID_H:    regVal = AFU_ID_H;
      CSR_SCRATCH: regVal = scratch;
      CSR_CTRL:    regVal = {ctrl_cfg, 1'b0};
      CSR_STATUS:  regVal = status;
      CSR_ERROR:   regVal = err;
      CSR_CYCLE:   regVal = cycleCnt;
      default:     regVal = 64'h0;
    endcase
  end

  always_comb begin
    rdData = 64'h0;
    if (rdZero1)
      rdData = 64'h0;
    else if (rdIs81)
      rdData = regVal;
    else if (rdHalf1)
      rdData = {32'h0, regVal[63:32]};
    else
      rdData = {32'h0, regVal[31:0]};
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      c2Tx <= '0;
    end else begin
      c2Tx.mmioRdValid <= rdValid1;
      c2Tx.hdr.tid     <= rdTid1;
      c2Tx.data        <= rdData;
    end
  end

endmodule

// File: tb/tb_afu_csr.sv
// tb/tb_afu_csr.sv - scoreboard bench for afu_csr MMIO reads, writes and reset behaviour
module tb_afu_csr;
  import afu_csr_pkg::*;

  localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] STAT = 64'h1234_5678_9ABC_DEF0;

  logic           pClk;
  logic           rstN;
  t_if_ccip_Rx    sRx;
  t_if_ccip_c2_Tx c2Tx;
  logic           ctrlStart;
  logic [62:0]    ctrlCfg;
  logic [63:0]    status;
  logic [63:0]    errSet;
  logic [63:0]    err;

  afu_csr #(.AFU_ID_L(ID_L), .AFU_ID_H(ID_H)) dut (
    .pClk                  (pClk),
    .pck_cp2af_softReset_n (rstN),
    .sRx                   (sRx),
    .c2Tx                  (c2Tx),
    .ctrl_start            (ctrlStart),
    .ctrl_cfg              (ctrlCfg),
    .status                (status),
    .err_set               (errSet),
    .err                   (err)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  int tbCycle = 0;
  always @(posedge pClk) tbCycle <= tbCycle + 1;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
  } t_exp;

  t_exp expQ[$];
  int   nVec  = 0;
  int   nFail = 0;

  // Responses are checked for tid, data and arrival cycle against the queued expectation.
  always @(negedge pClk) begin
    if (c2Tx.mmioRdValid) begin
      nVec++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL unexpected_rsp tid=%h data=%h cycle=%0d", c2Tx.hdr.tid, c2Tx.data, tbCycle);
      end else begin
        t_exp e;
        e = expQ.pop_front();
        if (c2Tx.hdr.tid !== e.tid || c2Tx.data !== e.data || tbCycle != e.due) begin
          nFail++;
          $display("FAIL rsp got tid=%h data=%h cycle=%0d exp tid=%h data=%h cycle=%0d",
                   c2Tx.hdr.tid, c2Tx.data, tbCycle, e.tid, e.data, e.due);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pClk);
      #1;
    end
  endtask

  task automatic mmioWr(input logic [15:0] dw, input logic is8, input logic [63:0] d);
    sRx.c0.hdr.address = dw;
    sRx.c0.hdr.length  = is8 ? 2'd1 : 2'd0;
    sRx.c0.hdr.tid     = 9'h0;
    sRx.c0.data        = {448'h0, d};
    sRx.c0.mmioWrValid = 1'b1;
    tick(1);
    sRx.c0.mmioWrValid = 1'b0;
  endtask

  task automatic mmioRd(input logic [15:0] dw, input logic is8, input logic [8:0] tid,
                        input logic [63:0] expData, input logic push);
    t_exp e;
    sRx.c0.hdr.address = dw;
    sRx.c0.hdr.length  = is8 ? 2'd1 : 2'd0;
    sRx.c0.hdr.tid     = tid;
    sRx.c0.mmioRdValid = 1'b1;
    if (push) begin
      e.tid  = tid;
      e.data = expData;
      e.due  = tbCycle + 2;
      expQ.push_back(e);
    end
    tick(1);
    sRx.c0.mmioRdValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN   = 1'b0;
    sRx    = '0;
    status = STAT;
    errSet = 64'h0;
    tick(3);
    chk("rst_c2_valid", {63'h0, c2Tx.mmioRdValid}, 64'h0);
    chk("rst_c2_data", c2Tx.data, 64'h0);
    chk("rst_c2_tid", {55'h0, c2Tx.hdr.tid}, 64'h0);
    chk("rst_ctrl_start", {63'h0, ctrlStart}, 64'h0);
    chk("rst_ctrl_cfg", {1'b0, ctrlCfg}, 64'h0);
    chk("rst_err", err, 64'h0);
    rstN = 1'b1;
    tick(2);

    mmioRd(16'h0000, 1'b1, 9'h1A, AFU_DFH_DEFAULT, 1'b1);
    mmioRd(16'h0002, 1'b1, 9'h1B, ID_L, 1'b1);
    mmioRd(16'h0004, 1'b1, 9'h1C, ID_H, 1'b1);
    tick(3);

    mmioWr(16'h000A, 1'b1, 64'hDEAD_BEEF_0123_4567);
    mmioWr(16'h000B, 1'b0, 64'h0000_0000_CAFE_F00D);
    mmioRd(16'h000A, 1'b1, 9'h20, 64'hCAFE_F00D_0123_4567, 1'b1);
    mmioRd(16'h000A, 1'b0, 9'h21, 64'h0000_0000_0123_4567, 1'b1);
    mmioRd(16'h000B, 1'b0, 9'h22, 64'h0000_0000_CAFE_F00D, 1'b1);
    tick(3);

    mmioWr(16'h000C, 1'b1, 64'h5);
    chk("ctrl_start_pulse", {63'h0, ctrlStart}, 64'h1);
    chk("ctrl_cfg", {1'b0, ctrlCfg}, 64'h2);
    tick(1);
    chk("ctrl_start_drop", {63'h0, ctrlStart}, 64'h0);
    mmioRd(16'h000C, 1'b1, 9'h30, 64'h4, 1'b1);
    mmioWr(16'h000D, 1'b0, 64'h1);
    chk("ctrl_hi_no_start", {63'h0, ctrlStart}, 64'h0);
    chk("ctrl_hi_cfg", {1'b0, ctrlCfg}, 64'h0000_0000_8000_0002);
    mmioRd(16'h000C, 1'b1, 9'h31, 64'h0000_0001_0000_0004, 1'b1);
    tick(3);

    errSet = 64'h3;
    tick(1);
    errSet = 64'h0;
    chk("err_set", err, 64'h3);
    mmioRd(16'h0010, 1'b1, 9'h40, 64'h3, 1'b1);
    errSet = 64'h1;
    mmioWr(16'h0010, 1'b1, 64'h1);
    errSet = 64'h0;
    chk("err_set_wins", err, 64'h3);
    mmioWr(16'h0010, 1'b1, 64'h3);
    chk("err_clear", err, 64'h0);

    mmioRd(16'h000E, 1'b1, 9'h41, STAT, 1'b1);
    mmioRd(16'h000F, 1'b0, 9'h42, 64'h0000_0000_1234_5678, 1'b1);
    tick(3);

    mmioWr(16'h0012, 1'b1, 64'hABCD);
    mmioRd(16'h0012, 1'b1, 9'h50, 64'd1, 1'b1);
    tick(3);
    mmioRd(16'h0012, 1'b1, 9'h51, 64'd5, 1'b1);
    mmioWr(16'h0013, 1'b0, 64'h7);
    mmioRd(16'h0012, 1'b0, 9'h52, 64'd1, 1'b1);
    tick(3);

    mmioRd(16'h0012, 1'b1, 9'h53, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    force dut.cycleCnt = 64'hFFFF_FFFF_FFFF_FFFF;
    release dut.cycleCnt;
    mmioRd(16'h0012, 1'b1, 9'h54, 64'd0, 1'b1);
    mmioRd(16'h0012, 1'b1, 9'h55, 64'd1, 1'b1);
    tick(3);

    mmioRd(16'h0040, 1'b1, 9'h60, 64'h0, 1'b1);
    mmioRd(16'h000B, 1'b1, 9'h61, 64'h0, 1'b1);
    mmioWr(16'h000B, 1'b1, 64'h1111_2222_3333_4444);
    mmioRd(16'h000A, 1'b1, 9'h62, 64'hCAFE_F00D_0123_4567, 1'b1);
    tick(4);

    mmioRd(16'h0000, 1'b1, 9'h70, 64'h0, 1'b0);
    rstN = 1'b0;
    #1;
    chk("midrd_rst_valid", {63'h0, c2Tx.mmioRdValid}, 64'h0);
    tick(2);
    rstN = 1'b1;
    tick(5);
    chk("post_rst_ctrl_cfg", {1'b0, ctrlCfg}, 64'h0);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) tick(1);
    chk("queue_drained", 64'(expQ.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
